// File: rtl/dsp_mac_seq_if.sv
// Operand-pair input stream and dot-product result stream of dsp_mac_seq.
// MAC_SEQ_SUB_EN adds the per-pair subtract flag in_sub.
interface dsp_mac_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
`ifdef MAC_SEQ_SUB_EN
  logic        in_sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;

`ifdef MAC_SEQ_SUB_EN
  modport master (output in_valid, in_a, in_b, in_sub, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_a, in_b, in_sub, out_ready,
                  output in_ready, out_valid, out_data);
`else
  modport master (output in_valid, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/dsp_mac_seq.sv
// Drives a DSP48A1-style slice as an unsigned MAC over LEN pairs (MAC_SEQ_SUB_EN: per-pair subtract).
// Latency: result valid P_LAT+1 edges after the last pair is accepted; one result per LEN+P_LAT+2 cycles min.
// Backpressure: in_ready only in ACC; the result is held in DONE until out_ready.
module dsp_mac_seq #(
  parameter int LEN   = 8,
  parameter int P_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  dsp_mac_seq_if.slave strm,
  output logic [17:0]  dsp_a,
  output logic [17:0]  dsp_b,
  output logic [7:0]   dsp_opmode,
  output logic         dsp_ce,
  input  logic [47:0]  dsp_p,
  output logic         busy
);
  localparam int DCW = $clog2(P_LAT + 1) + 1;

  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [7:0]     cnt;
  logic [DCW-1:0] dcnt;
  logic [7:0]     tag_q;
  logic [7:0]     tag;
  logic           pend_vld;
  logic           hs;
  logic           last;
  logic           drain_end;
  logic           sub;

`ifdef MAC_SEQ_SUB_EN
  assign sub = strm.in_sub;
`else
  assign sub = 1'b0;
`endif

  assign last      = (cnt == 8'(LEN - 1));
  assign drain_end = (dcnt == DCW'(P_LAT));
  // First pair starts from Z=0 so stale P never leaks into a new sum.
  assign tag       = {sub, 3'b000, (cnt == 8'd0) ? 4'h1 : 4'h9};

  always_comb begin
    state_nxt     = state;
    strm.in_ready = 1'b0;
    dsp_ce        = 1'b0;
    busy          = 1'b0;
    hs            = 1'b0;
    case (state)
      ACC: begin
        strm.in_ready = 1'b1;
        dsp_ce        = strm.in_valid;
        hs            = strm.in_valid;
        if (strm.in_valid && last) state_nxt = DRAIN;
      end
      DRAIN: begin
        dsp_ce = 1'b1;
        busy   = 1'b1;
        if (drain_end) state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (strm.out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a          <= '0;
      dsp_b          <= '0;
      dsp_opmode     <= 8'h00;
      tag_q          <= 8'h00;
      pend_vld       <= 1'b0;
      cnt            <= 8'd0;
      dcnt           <= '0;
      strm.out_data  <= '0;
      strm.out_valid <= 1'b0;
    end else begin
      // Opmode trails operands by one ce edge to line up with the slice's A1->M stages.
      if (dsp_ce) begin
        dsp_opmode <= pend_vld ? tag_q : 8'h08;
        pend_vld   <= hs;
      end
      if (hs) begin
        dsp_a <= strm.in_a;
        dsp_b <= strm.in_b;
        tag_q <= tag;
        cnt   <= last ? 8'd0 : cnt + 8'd1;
        if (last) dcnt <= '0;
      end
      if (state == DRAIN) begin
        dcnt <= dcnt + DCW'(1);
        if (drain_end) begin
          strm.out_data  <= dsp_p;
          strm.out_valid <= 1'b1;
        end
      end
      if (state == DONE && strm.out_ready) begin
        strm.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural DSP48A1 slice (A1, M, P, OPMODE registers on dsp_ce).
module tb_dsp_mac_seq;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce;
  logic        busy;
  logic [47:0] dsp_p;

  dsp_mac_seq_if bus ();

  dsp_mac_seq #(.LEN(4), .P_LAT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .strm       (bus.slave),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_p      (dsp_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Slice model: unsigned multiply, X=M when opmode[1:0]=01, Z=P when opmode[3:2]=10, bit7 subtracts.
  logic [17:0] a1 = 18'h155;
  logic [17:0] b1 = 18'h2AA;
  logic [47:0] m  = 48'h1234;
  logic [47:0] p  = 48'h5A5A5;
  logic [7:0]  opreg = 8'h09;
  logic [47:0] xm;
  logic [47:0] zp;
  assign xm    = (opreg[1:0] == 2'b01) ? m : 48'd0;
  assign zp    = (opreg[3:2] == 2'b10) ? p : 48'd0;
  assign dsp_p = p;

  always @(posedge clk) begin
    if (dsp_ce) begin
      a1    <= dsp_a;
      b1    <= dsp_b;
      m     <= {30'd0, a1} * {30'd0, b1};
      opreg <= dsp_opmode;
      p     <= opreg[7] ? (zp - xm) : (zp + xm);
    end
  end

  // Record dsp_opmode after every ce edge while enabled.
  logic       ce_n = 1'b0;
  bit         rec  = 1'b0;
  logic [7:0] opq[$];
  always @(negedge clk) ce_n <= dsp_ce;
  always @(posedge clk) begin
    if (rec && ce_n) begin
      #1;
      opq.push_back(dsp_opmode);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    step();
    bus.in_valid = 1'b0;
  endtask

`ifdef MAC_SEQ_SUB_EN
  task automatic send_sub(input logic [17:0] a, input logic [17:0] b, input logic s);
    bus.in_sub = s;
    send(a, b);
    bus.in_sub = 1'b0;
  endtask
`endif

  // Returns the number of edges until out_valid is seen, or -1 after the budget.
  task automatic wait_out(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (bus.out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  logic [17:0] pa [4];
  logic [17:0] pb [4];
  int          gaps [4];
  int          n;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
`ifdef MAC_SEQ_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    bus.out_ready = 1'b1;
    pa   = '{18'd1, 18'd2, 18'd3, 18'd4};
    pb   = '{18'd5, 18'd6, 18'd7, 18'd8};
    gaps = '{1, 2, 0, 3};

    // Reset state
    repeat (2) step();
    chk("rst_in_ready",  48'(bus.in_ready),  48'd1);
    chk("rst_out_valid", 48'(bus.out_valid), 48'd0);
    chk("rst_out_data",  bus.out_data,       48'd0);
    chk("rst_dsp_a",     48'(dsp_a),         48'd0);
    chk("rst_dsp_b",     48'(dsp_b),         48'd0);
    chk("rst_opmode",    48'(dsp_opmode),    48'd0);
    chk("rst_busy",      48'(busy),          48'd0);
    chk("rst_ce",        48'(dsp_ce),        48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Back-to-back pairs: 5+12+21+32 = 70
    for (int i = 0; i < 4; i++) send(pa[i], pb[i]);
    chk("t1_busy_drain",  48'(busy),         48'd1);
    chk("t1_inrdy_drain", 48'(bus.in_ready), 48'd0);
    chk("t1_ce_drain",    48'(dsp_ce),       48'd1);
    chk("t1_dsp_a_hold",  48'(dsp_a),        48'd4);
    wait_out(40, n);
    chk("t1_latency",     48'(n),            48'd4);
    chk("t1_data",        bus.out_data,      48'd70);
    step();
    chk("t1_valid_pulse", 48'(bus.out_valid), 48'd0);
    chk("t1_inrdy_back",  48'(bus.in_ready),  48'd1);

    // Same pairs with in_valid gaps; ce must stay low on gaps
    opq.delete();
    rec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        #1;
        chk("t2_gap_ce", 48'(dsp_ce), 48'd0);
        step();
      end
      send(pa[i], pb[i]);
    end
    wait_out(40, n);
    chk("t2_latency", 48'(n),       48'd4);
    chk("t2_data",    bus.out_data, 48'd70);
    step();
    rec = 1'b0;
    chk("t2_ce_edges", 48'(opq.size()), 48'd8);
    if (opq.size() >= 6) begin
      chk("t2_op1", 48'(opq[1]), 48'h01);
      chk("t2_op2", 48'(opq[2]), 48'h09);
      chk("t2_op3", 48'(opq[3]), 48'h09);
      chk("t2_op4", 48'(opq[4]), 48'h09);
      chk("t2_op5", 48'(opq[5]), 48'h08);
    end

    // Max operands: 4 * 0xF_FFF8_0001
    for (int i = 0; i < 4; i++) send(18'h3FFFF, 18'h3FFFF);
    wait_out(40, n);
    chk("t3_max_seen", 48'(n >= 0), 48'd1);
    chk("t3_max_data", bus.out_data, 48'h3F_FFE0_0004);
    step();
    for (int i = 0; i < 4; i++) send(18'd1, 18'd1);
    wait_out(40, n);
    chk("t3_restart_data", bus.out_data, 48'd4);
    step();

    // Held result: 25+36+49+64 = 174
    bus.out_ready = 1'b0;
    send(18'd5, 18'd5);
    send(18'd6, 18'd6);
    send(18'd7, 18'd7);
    send(18'd8, 18'd8);
    wait_out(40, n);
    chk("t4_seen", 48'(n >= 0), 48'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = 18'd9;
    bus.in_b     = 18'd9;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_hold_data",  bus.out_data,        48'd174);
      chk("t4_hold_valid", 48'(bus.out_valid),  48'd1);
      chk("t4_hold_inrdy", 48'(bus.in_ready),   48'd0);
      chk("t4_hold_ce",    48'(dsp_ce),         48'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("t4_release_valid", 48'(bus.out_valid), 48'd0);
    chk("t4_release_inrdy", 48'(bus.in_ready),  48'd1);

    // Asynchronous reset in DRAIN, then (2,3)x4 = 24
    for (int i = 0; i < 4; i++) send(18'd1, 18'd1);
    step();
    chk("t5_busy_pre", 48'(busy), 48'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_dsp_a",   48'(dsp_a),          48'd0);
    chk("t5_rst_dsp_b",   48'(dsp_b),          48'd0);
    chk("t5_rst_opmode",  48'(dsp_opmode),     48'd0);
    chk("t5_rst_valid",   48'(bus.out_valid),  48'd0);
    chk("t5_rst_data",    bus.out_data,        48'd0);
    chk("t5_rst_busy",    48'(busy),           48'd0);
    chk("t5_rst_ce",      48'(dsp_ce),         48'd0);
    chk("t5_rst_inrdy",   48'(bus.in_ready),   48'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send(18'd2, 18'd3);
    wait_out(40, n);
    chk("t5_latency", 48'(n),       48'd4);
    chk("t5_data",    bus.out_data, 48'd24);
    step();

`ifdef MAC_SEQ_SUB_EN
    // 100 - 6 + 1 + 0 = 95
    send_sub(18'd10, 18'd10, 1'b0);
    send_sub(18'd3,  18'd2,  1'b1);
    send_sub(18'd1,  18'd1,  1'b0);
    send_sub(18'd0,  18'd5,  1'b0);
    wait_out(40, n);
    chk("t6_sub_data", bus.out_data, 48'd95);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
